// File: rtl/micro_sequencer.sv
// Next-address sequencer for the multicycle core's microcode ROM: micro-PC, opcode and
// load/store dispatch, gating of the microword write enables, and the retired-instruction count.
module micro_sequencer #(
    parameter int UPC_W = 5,
    parameter int UW_W  = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [UW_W-1:0]  rom_dout,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             stall,
    output logic [UPC_W-1:0] upc,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             alu_op,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_control,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [4:0] {
        S_FETCH     = 5'd0,
        S_DECODE    = 5'd1,
        S_MEMADR    = 5'd2,
        S_MEMREAD   = 5'd3,
        S_MEMWB     = 5'd4,
        S_MEMWRITE  = 5'd5,
        S_EXEC_ADD  = 5'd6,
        S_EXEC_ADDI = 5'd7,
        S_ALUWB     = 5'd8,
        S_BEQ       = 5'd9,
        S_EXEC_SUB  = 5'd10,
        S_EXEC_AND  = 5'd11,
        S_EXEC_OR   = 5'd12,
        S_RESERVED  = 5'd13,
        S_EXEC_ANDI = 5'd14,
        S_EXEC_ORI  = 5'd15
    } ustate_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [4:0] NA_DISP1 = 5'b11111;
    localparam logic [4:0] NA_DISP2 = 5'b11110;

    // Dispatch results are {illegal, target}; the target is don't-care when illegal.
    function automatic logic [5:0] dispatch1(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7b5);
        logic [5:0] r;
        r = {1'b1, S_FETCH};
        case (op)
            OP_LW, OP_SW: r = {1'b0, S_MEMADR};
            OP_BEQ:       r = {1'b0, S_BEQ};
            OP_R: begin
                case (f3)
                    3'b000:  r = f7b5 ? {1'b0, S_EXEC_SUB} : {1'b0, S_EXEC_ADD};
                    3'b111:  r = {1'b0, S_EXEC_AND};
                    3'b110:  r = {1'b0, S_EXEC_OR};
                    default: r = {1'b1, S_FETCH};
                endcase
            end
            OP_I: begin
                case (f3)
                    3'b000:  r = {1'b0, S_EXEC_ADDI};
                    3'b111:  r = {1'b0, S_EXEC_ANDI};
                    3'b110:  r = {1'b0, S_EXEC_ORI};
                    default: r = {1'b1, S_FETCH};
                endcase
            end
            default: r = {1'b1, S_FETCH};
        endcase
        return r;
    endfunction

    function automatic logic [5:0] dispatch2(input logic [6:0] op);
        logic [5:0] r;
        case (op)
            OP_LW:   r = {1'b0, S_MEMREAD};
            OP_SW:   r = {1'b0, S_MEMWRITE};
            default: r = {1'b1, S_FETCH};
        endcase
        return r;
    endfunction

    logic [UPC_W-1:0] upc_q, upc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [4:0]       next_adr;
    logic [5:0]       disp;
    logic             illegal;
    logic             advance;
    logic             retire;
    logic             en_gate;

    always_comb begin
        next_adr = rom_dout[4:0];
        disp     = {1'b0, next_adr};
        if (next_adr == NA_DISP1) begin
            disp = dispatch1(opcode, funct3, funct7b5);
        end else if (next_adr == NA_DISP2) begin
            disp = dispatch2(opcode);
        end
        illegal = disp[5];
        advance = ~stall & ~halted_q;

        upc_d     = upc_q;
        halted_d  = halted_q;
        instret_d = instret_q;
        // An illegal dispatch leaves upc frozen on the dispatching state.
        if (advance) begin
            if (illegal) begin
                halted_d = 1'b1;
            end else begin
                upc_d = UPC_W'(disp[4:0]);
            end
        end
        retire = advance & ~illegal & (upc_d == '0) & (upc_q != '0);
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q     <= '0;
            halted_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            upc_q     <= upc_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
        end
    end

    // rst_n in the gate keeps enables low immediately, without waiting for a clock edge.
    assign en_gate     = rst_n & ~stall & ~halted_q;
    assign pc_write    = (rom_dout[17] | (rom_dout[18] & zero)) & en_gate;
    assign reg_write   = rom_dout[16] & en_gate;
    assign mem_write   = rom_dout[15] & en_gate;
    assign ir_write    = rom_dout[14] & en_gate;
    assign alu_op      = rom_dout[19];
    assign adr_src     = rom_dout[13];
    assign result_src  = rom_dout[12:11];
    assign alu_src_a   = rom_dout[10:9];
    assign alu_src_b   = rom_dout[8:7];
    assign alu_control = rom_dout[6:5];

    assign upc     = upc_q;
    assign halted  = halted_q;
    assign instret = instret_q;

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address sequencer for the multicycle core's 20-bit microcode ROM. It holds the micro-PC that addresses the ROM and resolves the two dispatch codes (opcode dispatch from Decode, load/store dispatch from MemAdr) from the instruction fields. It also applies the branch condition, stall and halt gating to the microword's enable bits, and counts retired instructions. It sits between the ROM and the datapath; all datapath control comes through this block.

## Interface
- UPC_W, 5, micro-PC / ROM address width
- UW_W, 20, microword width
- CNT_W, 16, retired-instruction counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rom_dout  input  UW_W  microword from ROM
  - [19] alu_op, [18] branch, [17] next_pc, [16] reg_w, [15] mem_w, [14] ir_w, [13] adr_src
  - [12:11] result_src, [10:9] alu_src_a, [8:7] alu_src_b, [6:5] alu_control, [4:0] next_adr
- opcode  input  7  instruction opcode from IR
- funct3  input  3  instruction funct3 from IR
- funct7b5  input  1  instruction bit 30
- zero  input  1  ALU zero flag
- stall  input  1  memory not ready; hold current microstate
- upc  output  UPC_W  registered ROM address
- pc_write, reg_write, mem_write, ir_write  output  1 each  gated write enables
- adr_src, alu_op  output  1 each  pass-through of microword bits
- result_src, alu_src_a, alu_src_b, alu_control  output  2 each  pass-through of microword fields
- halted  output  1  sticky illegal-instruction flag
- instret  output  CNT_W  retired-instruction count

## Operation
- Next-address select on next_adr:
  - 11111 is dispatch 1.
  - 11110 is dispatch 2.
  - Any other value is a direct next upc.
- Dispatch 1 (keyed on opcode):
  - 0000011 lw and 0100011 sw go to 00010.
  - 1100011 beq goes to 01001.
  - 0110011 R-type, by funct3 and funct7b5:
    - funct3 000 with funct7b5=0 goes to 00110; with funct7b5=1 goes to 01010.
    - funct3 111 goes to 01011; funct3 110 goes to 01100.
    - Any other funct3 is illegal.
  - 0010011 I-type, by funct3:
    - 000 goes to 00111; 111 goes to 01110; 110 goes to 01111.
    - Any other funct3 is illegal.
  - Any other opcode is illegal.
- Dispatch 2: lw goes to 00011, sw goes to 00101, any other opcode is illegal.
- Address 01101 is reserved; no dispatch path reaches it.
- Illegal dispatch: set halted and freeze upc at its current value. Only reset clears halted.
- pc_write = (next_pc | (branch & zero)) & ~stall & ~halted.
- reg_write, mem_write and ir_write equal their microword bits ANDed with ~stall & ~halted.
- All write enables are forced to 0 while rst_n is low.
- Non-enable fields pass straight through from rom_dout combinationally.
- stall=1 holds upc and instret unchanged.
- Retire: instret increments by 1 on each edge where the next upc is 00000, the current upc is not 00000, and there is no stall and no halt.
  - instret wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (asynchronous, immediate):
  - upc=00000 (Fetch), halted=0, instret=0.
  - All write enables are 0.
- upc, halted and instret update only on the rising edge of clk.
- Dispatch, gating and control outputs are combinational from upc/rom_dout and IR fields in the same cycle.
- Instruction latency in cycles, Fetch to Fetch, with no stall:
  - lw 5 (00000, 00001, 00010, 00011, 00100).
  - sw 4.
  - R-type and I-type 4 (via Execute then AluWb 01000).
  - beq 3.
- Stall: each stalled cycle extends the current microstate by one cycle with enables suppressed. The microword repeats in full once stall drops.
- Stall together with an illegal dispatch: halted is not set until the first unstalled edge.
- Halt takes effect on the edge after the illegal dispatch cycle. The illegal instruction does not increment instret.
- Reset asserted mid-instruction aborts it. Fetch restarts on the first edge after rst_n rises.

## Test plan
- Reset with rst_n=0 mid-MemRead -> upc=0, halted=0, instret=0, all enables 0, all asynchronous (before the next edge).
- lw (opcode 0000011), no stall -> upc sequence 0,1,2,3,4,0; reg_write=1 only in state 4; instret 0→1 on the 5th edge.
- add then sub (funct7b5=1) -> Execute states 00110 then 01010 respectively; each instruction 4 cycles; instret=2.
- beq with zero=1, then with zero=0 -> pc_write=1 in state 01001 only when zero=1; both take 3 cycles.
- sw with stall=1 for 3 cycles in state 00101 -> upc held for 4 cycles total; mem_write=0 while stalled, 1 in the release cycle; instret +1 once.
- opcode 1111111 at Decode -> halted=1 after that edge, upc frozen at 00001, all enables 0 for 10+ cycles, instret unchanged; rst_n pulse clears halted.
